uart_rx: RTL

- UART receiver; sits directly downstream of the baud rate generator and consumes its one-cycle `flag_max_tick` as the oversampling tick, at 16 ticks per bit.
- Detects a start bit, samples DBIT data bits LSB-first at mid-bit and checks the stop bit.
- Presents the received word with a one-cycle done pulse and a framing-error flag to the RX FIFO / interface stage.

---
 rtl/uart_rx.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : UART receiver with 16x oversampling. It detects the start bit,
//            samples DBIT data bits LSB-first at mid-bit and checks the stop
//            bit. It presents the word with a one-cycle done pulse and a
//            framing-error flag.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int DBIT    = 8,   // data bits per frame (5..8)
    parameter int SB_TICK = 16   // stop-bit length in ticks (16/24/32)
) (
    input  logic            i_clk,
    input  logic            i_reset,        // asynchronous, active low
    input  logic            i_rx,
    input  logic            i_s_tick,
    output logic [DBIT-1:0] o_dout,
    output logic            o_rx_done_tick,
    output logic            o_frame_err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int         c_N_W    = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [c_N_W-1:0] c_N_LAST = c_N_W'(DBIT - 1);
    // Tick index of the middle of the start bit (8th tick of 16).
    localparam logic [4:0] c_S_MID  = 5'd7;
    // Last tick of a full data bit.
    localparam logic [4:0] c_S_BIT  = 5'd15;
    // Last tick of the stop period. This is the point where the stop level is judged.
    localparam logic [4:0] c_S_STOP = 5'(SB_TICK - 1);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t            r_state;
    logic [4:0]        r_s;        // oversampling tick counter
    logic [c_N_W-1:0]  r_n;        // data bit counter
    logic [DBIT-1:0]   r_b;        // shift register, LSB arrives first
    logic              r_rx_meta;  // first synchroniser stage
    logic              r_rx_sync;  // synchronised serial line

    // ------------------------------------------------------------------------
    // Two-flop synchroniser. It resets to the idle (high) line level so that
    // reset release never looks like a start bit.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // ------------------------------------------------------------------------
    // Receive FSM with counters and registered outputs. The done pulse
    // defaults low every cycle, so it is high only in the cycle after
    // the stop tick.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state        <= ST_IDLE;
            r_s            <= '0;
            r_n            <= '0;
            r_b            <= '0;
            o_dout         <= '0;
            o_frame_err    <= 1'b0;
            o_rx_done_tick <= 1'b0;
        end else begin
            o_rx_done_tick <= 1'b0;
            case (r_state)
                // Falling edge detection runs every clock, not only on ticks.
                ST_IDLE: begin
                    if (!r_rx_sync) begin
                        r_state <= ST_START;
                        r_s     <= '0;
                    end
                end

                // Re-check the line at mid start bit to reject glitches.
                ST_START: begin
                    if (i_s_tick) begin
                        if (r_s == c_S_MID) begin
                            if (!r_rx_sync) begin
                                r_state <= ST_DATA;
                                r_s     <= '0;
                                r_n     <= '0;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_s <= r_s + 5'd1;
                        end
                    end
                end

                // Sample 16 ticks after the previous mid-bit point, which is
                // the middle of the current data bit.
                ST_DATA: begin
                    if (i_s_tick) begin
                        if (r_s == c_S_BIT) begin
                            r_s <= '0;
                            r_b <= {r_rx_sync, r_b[DBIT-1:1]};
                            if (r_n == c_N_LAST) begin
                                r_state <= ST_STOP;
                            end else begin
                                r_n <= r_n + 1'b1;
                            end
                        end else begin
                            r_s <= r_s + 5'd1;
                        end
                    end
                end

                // Deliver the word even on a framing error; the flag tells
                // the consumer the stop bit was low.
                ST_STOP: begin
                    if (i_s_tick) begin
                        if (r_s == c_S_STOP) begin
                            o_dout         <= r_b;
                            o_frame_err    <= ~r_rx_sync;
                            o_rx_done_tick <= 1'b1;
                            r_state        <= ST_IDLE;
                        end else begin
                            r_s <= r_s + 5'd1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
